// File: rtl/dram_pack.sv
// ---------------------------------------------------------------------------
// dram_pack
//   Shared types and default timing constants for the DRAM timing controller.
//   The package provides:
//     cmd_fsm_t  - command-FSM state that the timing controller observes
//     init_fsm_t - power-up init sequencer state
//     DEF_T_*    - default timing values, in clock cycles
//     maxOf / timerWidth / isTimed - helpers for elaboration and decode
// ---------------------------------------------------------------------------
package dram_pack;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ACTIVATE  = 3'd1,
        WRITE     = 3'd2,
        READ      = 3'd3,
        PRECHARGE = 3'd4,
        REFRESH   = 3'd5
    } cmd_fsm_t;

    typedef enum logic [1:0] {
        INIT_IDLE = 2'd0,
        INIT_WAIT = 2'd1,
        INIT_DONE = 2'd2
    } init_fsm_t;

    localparam int DEF_T_RCD  = 14;
    localparam int DEF_T_WR   = 15;
    localparam int DEF_T_RL   = 22;
    localparam int DEF_T_RP   = 14;
    localparam int DEF_T_RFC  = 350;
    localparam int DEF_T_REFI = 7800;
    localparam int DEF_T_INIT = 200;

    function automatic int maxOf(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // A timer only ever holds T-1, so $clog2(T) bits are enough; keep at
    // least one bit so every timing value of 1 still builds.
    function automatic int timerWidth(input int maxVal);
        int w;
        w = $clog2(maxVal);
        return (w < 1) ? 1 : w;
    endfunction

    // States that start a timed interval when entered.
    function automatic logic isTimed(input cmd_fsm_t s);
        return (s == ACTIVATE) || (s == WRITE) || (s == READ) ||
               (s == PRECHARGE) || (s == REFRESH);
    endfunction

endpackage

// File: rtl/dram_timing_ctrl_if.sv
// ---------------------------------------------------------------------------
// dram_timing_ctrl_if
//   Bundle between the command FSM (master) and the timing controller (slave).
//     cmd_state  master->slave  current command-FSM state
//     init_req   master->slave  request to run power-up init timing
//     init_done  slave->master  init timing complete (sticky until reset)
//     tACT_done, tWR_done, tRD_done, tPRE_done, tREF_done
//                slave->master  one-cycle timing-complete pulses
//     rf_req     slave->master  refresh due, held until REFRESH is entered
// ---------------------------------------------------------------------------
interface dram_timing_ctrl_if;
    import dram_pack::*;

    cmd_fsm_t cmd_state;
    logic     init_req;
    logic     init_done;
    logic     tACT_done;
    logic     tWR_done;
    logic     tRD_done;
    logic     tPRE_done;
    logic     tREF_done;
    logic     rf_req;

    modport master (
        output cmd_state, init_req,
        input  init_done, tACT_done, tWR_done, tRD_done, tPRE_done, tREF_done,
               rf_req
    );

    modport slave (
        input  cmd_state, init_req,
        output init_done, tACT_done, tWR_done, tRD_done, tPRE_done, tREF_done,
               rf_req
    );

endinterface

// File: rtl/dram_down_counter.sv
// ---------------------------------------------------------------------------
// dram_down_counter
//   Loadable down-counter used for every timer in the controller.
//   A load takes effect in the cycle it is asserted: the value presented on
//   `value` is the count for that cycle, and `zero` reflects it at once.
//   This lets a timer loaded with T-1 report zero exactly T-1 cycles after
//   the load cycle (and in the load cycle itself when T is 1).
//   Ports:
//     CLK, nRST  clock, asynchronous active-low reset
//     load       take `value` as the current count this cycle
//     value      load value
//     enable     count down this cycle (saturates at zero)
//     zero       current count (after any load) is zero
// ---------------------------------------------------------------------------
module dram_down_counter #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    input  logic             enable,
    output logic             zero
);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cur;

    assign cur  = load ? value : cnt;
    assign zero = (cur == '0);

    // NOTE: sequential state is written with <= so every flop samples the
    // pre-edge values; a blocking = here would let later statements see the
    // updated value and break the register model.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt <= '0;
        end else if (load || enable) begin
            cnt <= zero ? '0 : cur - WIDTH'(1);
        end
    end

endmodule

// File: rtl/dram_timing_ctrl.sv
// ---------------------------------------------------------------------------
// dram_timing_ctrl
//   Observes the command FSM and produces timing-complete pulses for the
//   timed states, the power-up init delay and (optionally) refresh requests.
//   Ports:
//     CLK        single clock, all state on the rising edge
//     nRST       asynchronous active-low reset
//     bus        dram_timing_ctrl_if.slave (cmd_state, init_req in;
//                init_done, t*_done pulses, rf_req out)
//   Parameters T_RCD/T_WR/T_RL/T_RP/T_RFC/T_REFI/T_INIT are in cycles and
//   must be at least 1.
//   Build option: define DRAM_AUTO_REFRESH_EN to include the refresh-interval
//   timer and rf_req; without it rf_req is tied low (tREF_done still works).
// ---------------------------------------------------------------------------
module dram_timing_ctrl
    import dram_pack::*;
#(
    parameter int T_RCD  = DEF_T_RCD,
    parameter int T_WR   = DEF_T_WR,
    parameter int T_RL   = DEF_T_RL,
    parameter int T_RP   = DEF_T_RP,
    parameter int T_RFC  = DEF_T_RFC,
    parameter int T_REFI = DEF_T_REFI,
    parameter int T_INIT = DEF_T_INIT
) (
    input  logic              CLK,
    input  logic              nRST,
    dram_timing_ctrl_if.slave bus
);

    localparam int MAX_T = maxOf(maxOf(maxOf(T_RCD, T_WR), maxOf(T_RL, T_RP)),
                                 maxOf(maxOf(T_RFC, T_REFI), T_INIT));
    localparam int CNT_W = timerWidth(MAX_T);

    localparam logic [CNT_W-1:0] RCD_LD  = CNT_W'(T_RCD - 1);
    localparam logic [CNT_W-1:0] WR_LD   = CNT_W'(T_WR - 1);
    localparam logic [CNT_W-1:0] RL_LD   = CNT_W'(T_RL - 1);
    localparam logic [CNT_W-1:0] RP_LD   = CNT_W'(T_RP - 1);
    localparam logic [CNT_W-1:0] RFC_LD  = CNT_W'(T_RFC - 1);
    localparam logic [CNT_W-1:0] INIT_LD = CNT_W'(T_INIT - 1);

    // -----------------------------------------------------------------------
    // Init sequencer
    // -----------------------------------------------------------------------
    init_fsm_t initState;
    logic      initLoad;
    logic      initZero;
    logic      initDone;

    assign initLoad = (initState == INIT_IDLE) && bus.init_req;
    assign initDone = (initState == INIT_DONE);

    dram_down_counter #(.WIDTH(CNT_W)) uInitTimer (
        .CLK    (CLK),
        .nRST   (nRST),
        .load   (initLoad),
        .value  (INIT_LD),
        .enable (initState == INIT_WAIT),
        .zero   (initZero)
    );

    // A request whose load value is already zero (T_INIT == 1) completes in
    // the request cycle, so it skips the wait state to keep the latency at
    // exactly T_INIT cycles. init_req is ignored outside INIT_IDLE.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            initState <= INIT_IDLE;
        end else begin
            case (initState)
                INIT_IDLE: if (bus.init_req) initState <= initZero ? INIT_DONE : INIT_WAIT;
                INIT_WAIT: if (initZero)     initState <= INIT_DONE;
                INIT_DONE:                   initState <= INIT_DONE;
                default:                     initState <= INIT_IDLE;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Command timer: one shared counter, restarted on every timed-state entry
    // -----------------------------------------------------------------------
    cmd_fsm_t         prevState;
    cmd_fsm_t         cmdTarget;
    logic             cmdActive;
    logic             cmdEntry;
    logic             cmdStillIn;
    logic             cmdCounting;
    logic             cmdZero;
    logic             cmdFire;
    logic [CNT_W-1:0] cmdLoadVal;

    assign cmdEntry    = (bus.cmd_state != prevState) && isTimed(bus.cmd_state);
    // A running count is only meaningful while the FSM stays in the state
    // that started it; leaving that state silently drops the count.
    assign cmdStillIn  = cmdActive && (bus.cmd_state == cmdTarget);
    assign cmdCounting = cmdEntry || cmdStillIn;
    assign cmdFire     = cmdCounting && cmdZero && initDone;

    // NOTE: always_comb assigns a default before the case so every path
    // drives cmdLoadVal; a missing default would infer a latch.
    always_comb begin
        cmdLoadVal = '0;
        case (bus.cmd_state)
            ACTIVATE:  cmdLoadVal = RCD_LD;
            WRITE:     cmdLoadVal = WR_LD;
            READ:      cmdLoadVal = RL_LD;
            PRECHARGE: cmdLoadVal = RP_LD;
            REFRESH:   cmdLoadVal = RFC_LD;
            default:   cmdLoadVal = '0;
        endcase
    end

    dram_down_counter #(.WIDTH(CNT_W)) uCmdTimer (
        .CLK    (CLK),
        .nRST   (nRST),
        .load   (cmdEntry),
        .value  (cmdLoadVal),
        .enable (cmdStillIn),
        .zero   (cmdZero)
    );

    // The count retires on its zero cycle, so holding the state afterwards
    // gives no second pulse until the state is entered again.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            prevState <= IDLE;
            cmdTarget <= IDLE;
            cmdActive <= 1'b0;
        end else begin
            prevState <= bus.cmd_state;
            cmdActive <= cmdCounting && !cmdZero;
            if (cmdEntry) cmdTarget <= bus.cmd_state;
        end
    end

    // Whenever a count is live, cmd_state is the state that owns it, so the
    // pulse is steered by cmd_state and only one output can be high.
    assign bus.tACT_done = cmdFire && (bus.cmd_state == ACTIVATE);
    assign bus.tWR_done  = cmdFire && (bus.cmd_state == WRITE);
    assign bus.tRD_done  = cmdFire && (bus.cmd_state == READ);
    assign bus.tPRE_done = cmdFire && (bus.cmd_state == PRECHARGE);
    assign bus.tREF_done = cmdFire && (bus.cmd_state == REFRESH);
    assign bus.init_done = initDone;

    // -----------------------------------------------------------------------
    // Refresh-interval timer
    // -----------------------------------------------------------------------
`ifdef DRAM_AUTO_REFRESH_EN
    localparam logic [CNT_W-1:0] REFI_LD = CNT_W'(T_REFI - 1);

    logic initDoneQ;
    logic refExpiredQ;
    logic refZero;
    logic refExpire;
    logic refEntry;
    logic rfReq;

    assign refExpire = initDone && refZero;
    assign refEntry  = cmdEntry && (bus.cmd_state == REFRESH);

    // The interval starts in the cycle init_done rises. On expiry the counter
    // parks at zero for that cycle and is reloaded the next cycle with T-1,
    // which keeps the expiry spacing at exactly T_REFI cycles.
    dram_down_counter #(.WIDTH(CNT_W)) uRefTimer (
        .CLK    (CLK),
        .nRST   (nRST),
        .load   ((initDone && !initDoneQ) || refExpiredQ),
        .value  (REFI_LD),
        .enable (initDone),
        .zero   (refZero)
    );

    // Set wins over clear: an expiry coincident with REFRESH entry leaves a
    // request pending. Expiries while already pending are not counted.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            initDoneQ   <= 1'b0;
            refExpiredQ <= 1'b0;
            rfReq       <= 1'b0;
        end else begin
            initDoneQ   <= initDone;
            refExpiredQ <= refExpire;
            if (refExpire)     rfReq <= 1'b1;
            else if (refEntry) rfReq <= 1'b0;
        end
    end

    assign bus.rf_req = rfReq;
`else
    assign bus.rf_req = 1'b0;
`endif

endmodule

// File: tb/tb_dram_timing_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dram_timing_ctrl
//   Directed bench for dram_timing_ctrl with T_REFI overridden to 50.
//   Inputs change 1 time unit after the rising edge; outputs are sampled on
//   the falling edge. Offsets are counted in cycles from the cycle in which
//   the stimulus first becomes visible (cycle 0).
// ---------------------------------------------------------------------------
module tb_dram_timing_ctrl;
    import dram_pack::*;

    logic CLK;
    logic nRST;
    int   passed = 0;
    int   total  = 0;
    int   cyc    = 0;

    dram_timing_ctrl_if bus();

    dram_timing_ctrl #(.T_REFI(50)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus.slave)
    );

    logic [4:0] doneVec;
    assign doneVec = {bus.tREF_done, bus.tPRE_done, bus.tRD_done, bus.tWR_done, bus.tACT_done};

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Watch one done bit for n cycles starting with the current cycle.
    task automatic watch(input int n, input int bitIdx,
                         output int first, output int hits, output int others);
        logic [4:0] mask;
        mask   = 5'b00001 << bitIdx;
        first  = -1;
        hits   = 0;
        others = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge CLK);
            if (doneVec[bitIdx]) begin
                hits++;
                if (first < 0) first = k;
            end
            if ((doneVec & ~mask) != 5'b0) others++;
            step();
        end
    endtask

    initial begin
        int first, hits, others, rfFirst, dCyc, anyDone, rf0, rf1, rf45, rfHigh;

        nRST          = 1'b0;
        bus.cmd_state = IDLE;
        bus.init_req  = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_init_done", int'(bus.init_done), 0);
        check("rst_rf_req",    int'(bus.rf_req),    0);
        check("rst_dones",     int'(doneVec),       0);
        nRST = 1'b1;
        step();

        // Init: one-cycle request, with an ACTIVATE visit whose pulse would
        // land while init is still running.
        bus.init_req = 1'b1;
        first   = -1;
        rfFirst = -1;
        anyDone = 0;
        dCyc    = 0;
        for (int k = 0; k < 260; k++) begin
            @(negedge CLK);
            if (bus.init_done && first < 0) begin
                first = k;
                dCyc  = cyc;
            end
            if (bus.rf_req && rfFirst < 0) rfFirst = k;
            if (doneVec != 5'b0) anyDone++;
            step();
            if (k == 0)  bus.init_req  = 1'b0;
            if (k == 5)  bus.cmd_state = ACTIVATE;
            if (k == 30) bus.cmd_state = IDLE;
        end
        check("init_done_latency", first, 200);
        check("dones_before_init", anyDone, 0);
        check("init_done_held", int'(bus.init_done), 1);
`ifdef DRAM_AUTO_REFRESH_EN
        check("rf_req_first", rfFirst, 250);
`else
        check("rf_req_first", rfFirst, -1);
`endif
        bus.init_req = 1'b1;
        step();
        bus.init_req = 1'b0;
        repeat (3) step();
        check("init_req_ignored", int'(bus.init_done), 1);

        // ACTIVATE held: single pulse at offset T_RCD-1.
        bus.cmd_state = ACTIVATE;
        watch(40, 0, first, hits, others);
        check("act_first",  first,  13);
        check("act_hits",   hits,   1);
        check("act_others", others, 0);
        bus.cmd_state = IDLE;
        step();

        // READ left early: no pulse, no stale pulse; re-entry restarts.
        bus.cmd_state = READ;
        watch(10, 2, first, hits, others);
        check("rd_abort_hits", hits, 0);
        bus.cmd_state = IDLE;
        watch(30, 2, first, hits, others);
        check("rd_stale_hits", hits, 0);
        bus.cmd_state = READ;
        watch(30, 2, first, hits, others);
        check("rd_reentry_first", first, 21);
        check("rd_reentry_hits",  hits,  1);
        bus.cmd_state = IDLE;
        step();

        // WRITE aborted by PRECHARGE entry: counter reloads for tRP.
        bus.cmd_state = WRITE;
        watch(5, 1, first, hits, others);
        check("wr_aborted_hits", hits, 0);
        bus.cmd_state = PRECHARGE;
        watch(20, 3, first, hits, others);
        check("pre_first",  first,  13);
        check("pre_others", others, 0);
        bus.cmd_state = IDLE;
        step();

        // WRITE to completion.
        bus.cmd_state = WRITE;
        watch(20, 1, first, hits, others);
        check("wr_first", first, 14);
        check("wr_hits",  hits,  1);
        bus.cmd_state = IDLE;
        step();

`ifdef DRAM_AUTO_REFRESH_EN
        // Enter REFRESH 10 cycles after an interval start so no expiry
        // coincides with entry; the next re-set lands at offset 40.
        for (int i = 0; i < 50; i++) begin
            if (((cyc - dCyc) % 50) == 10) break;
            step();
        end
`else
        rfHigh = 0;
        for (int k = 0; k < 10000; k++) begin
            @(negedge CLK);
            if (bus.rf_req) rfHigh++;
            step();
        end
        check("rf_never_high", rfHigh, 0);
`endif
        bus.cmd_state = REFRESH;
        first = -1;
        hits  = 0;
        rf0   = 0;
        rf1   = 0;
        rf45  = 0;
        for (int k = 0; k < 360; k++) begin
            @(negedge CLK);
            if (k == 0)  rf0  = int'(bus.rf_req);
            if (k == 1)  rf1  = int'(bus.rf_req);
            if (k == 45) rf45 = int'(bus.rf_req);
            if (bus.tREF_done) begin
                hits++;
                if (first < 0) first = k;
            end
            step();
        end
`ifdef DRAM_AUTO_REFRESH_EN
        check("rf_at_entry",     rf0,  1);
        check("rf_after_entry",  rf1,  0);
        check("rf_next_expiry",  rf45, 1);
`else
        check("rf_at_entry",     rf0,  0);
        check("rf_after_entry",  rf1,  0);
        check("rf_next_expiry",  rf45, 0);
`endif
        check("ref_first", first, 349);
        check("ref_hits",  hits,  1);
        bus.cmd_state = IDLE;
        step();

        // Reset asserted in the tWR_done cycle, then released with WRITE held.
        bus.cmd_state = WRITE;
        watch(14, 1, first, hits, others);
        check("wr_pre_rst_hits", hits, 0);
        #1;
        check("wr_pulse_before_rst", int'(bus.tWR_done), 1);
        nRST = 1'b0;
        #1;
        check("rst_mid_dones",     int'(doneVec),       0);
        check("rst_mid_init_done", int'(bus.init_done), 0);
        check("rst_mid_rf_req",    int'(bus.rf_req),    0);
        repeat (2) @(negedge CLK);
        nRST = 1'b1;
        step();
        watch(40, 1, first, hits, others);
        check("wr_after_rst_hits", hits, 0);
        check("init_after_rst",    int'(bus.init_done), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
